stoch_fixed_gain_mult: RTL and testbench



---
 rtl/stoch_fixed_gain_mult.sv | 89 ++++++++
 tb/tb_stoch_fixed_gain_mult.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stoch_fixed_gain_mult.sv
// -----------------------------------------------------------------------------
// stoch_fixed_gain_mult
//
// Multiplies a unipolar stochastic bitstream by a fixed integer gain. The
// output density is min(1, GAIN * input density). Each input 1 (while enabled)
// adds GAIN credits to a counter. Each output 1 spends one credit, and at most
// one output 1 is produced per cycle. Credits that would push the counter
// above MAX_CREDIT are discarded, and the sticky sat flag records the loss.
//
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   synchronous active-high reset; also forces y low
//   en       in   advance enable; when low, y = 0 and the state holds
//   a        in   input stochastic bit
//   clr_sat  in   clears sat (an overflow in the same cycle wins)
//   y        out  output stochastic bit (zero latency from a)
//   credits  out  registered credit count
//   sat      out  sticky flag: credits were discarded at the ceiling
// -----------------------------------------------------------------------------
module stoch_fixed_gain_mult #(
  parameter int GAIN       = 2,
  parameter int MAX_CREDIT = 255,
  parameter int CW         = $clog2(MAX_CREDIT + GAIN + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  input  logic          a,
  input  logic          clr_sat,
  output logic          y,
  output logic [CW-1:0] credits,
  output logic          sat
);

  // The sum is one bit wider than the counter, so credits + GAIN cannot wrap.
  localparam logic [CW:0] GAIN_W = (CW + 1)'(GAIN);
  localparam logic [CW:0] MAX_W  = (CW + 1)'(MAX_CREDIT);

  logic [CW-1:0] r_credits;
  logic          r_sat;

  logic [CW:0]   w_c;
  logic          w_y;
  logic [CW:0]   w_n;
  logic          w_ovf;

  // NOTE: every combinational output gets a default at the top of the block,
  // so no path can leave it unassigned and no latch is inferred.
  always_comb begin
    w_c   = '0;
    w_y   = 1'b0;
    w_n   = '0;
    w_ovf = 1'b0;

    // With en low, a is ignored, so the counter sees no new credits.
    w_c = {1'b0, r_credits} + ((en && a) ? GAIN_W : '0);

    // Reset forces y low combinationally, even in the first cycle of reset.
    w_y = !RST && en && (w_c != '0);

    w_n   = w_c - {{CW{1'b0}}, w_y};
    w_ovf = (w_n > MAX_W);
  end

  // NOTE: state registers use non-blocking assignments, so every register
  // in this block samples the values from before the clock edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_credits <= '0;
      r_sat     <= 1'b0;
    end else begin
      if (w_ovf) begin
        r_credits <= MAX_W[CW-1:0];
        r_sat     <= 1'b1;
      end else begin
        r_credits <= w_n[CW-1:0];
        // Clearing applies only when this cycle does not overflow.
        if (clr_sat) begin
          r_sat <= 1'b0;
        end
      end
    end
  end

  assign y       = w_y;
  assign credits = r_credits;
  assign sat     = r_sat;

endmodule

// File: tb/tb_stoch_fixed_gain_mult.sv
// -----------------------------------------------------------------------------
// tb_stoch_fixed_gain_mult
//
// Self-checking bench for stoch_fixed_gain_mult with GAIN = 2 and
// MAX_CREDIT = 255. The driver applies one input vector per cycle and pushes
// the hand-derived expectation for that cycle into a queue. The monitor pops
// the queue. It compares y on the falling edge, before the update edge. It
// compares credits and sat just after the following rising edge.
// -----------------------------------------------------------------------------
module tb_stoch_fixed_gain_mult;

  localparam int GAIN       = 2;
  localparam int MAX_CREDIT = 255;
  localparam int CW         = $clog2(MAX_CREDIT + GAIN + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          en = 1'b0;
  logic          a = 1'b0;
  logic          clr_sat = 1'b0;
  logic          y;
  logic [CW-1:0] credits;
  logic          sat;

  typedef struct {
    string    name;
    logic     exp_y;
    int       exp_credits;
    logic     exp_sat;
  } exp_t;

  exp_t q_exp[$];

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_ones = 0;

  stoch_fixed_gain_mult #(
    .GAIN       (GAIN),
    .MAX_CREDIT (MAX_CREDIT)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .en      (en),
    .a       (a),
    .clr_sat (clr_sat),
    .y       (y),
    .credits (credits),
    .sat     (sat)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus and queues the expected response.
  task automatic step(input string name, input logic i_rst, input logic i_en,
                      input logic i_a, input logic i_clr, input logic e_y,
                      input int e_cr, input logic e_sat);
    exp_t e;
    @(posedge CLK);
    #1;
    RST     = i_rst;
    en      = i_en;
    a       = i_a;
    clr_sat = i_clr;
    e.name        = name;
    e.exp_y       = e_y;
    e.exp_credits = e_cr;
    e.exp_sat     = e_sat;
    q_exp.push_back(e);
  endtask

  // Waits until the monitor has consumed the y of the last queued cycle.
  task automatic settle_y();
    @(negedge CLK);
    #1;
  endtask

  // Monitor: pops one expectation per cycle and compares the outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q_exp.size() != 0) begin
        e = q_exp.pop_front();
        check({e.name, ".y"}, {31'd0, y}, {31'd0, e.exp_y});
        if (y === 1'b1) n_ones++;
        @(posedge CLK);
        #1;
        check({e.name, ".credits"}, 32'(credits), 32'(e.exp_credits));
        check({e.name, ".sat"}, {31'd0, sat}, {31'd0, e.exp_sat});
      end
    end
  end

  initial begin
    // Reset held for three cycles with a = 1, en = 1: y stays low.
    for (int i = 0; i < 3; i++) step("reset", 1, 1, 1, 0, 0, 0, 0);

    // Single pulse: y = 1,1,0 and credits = 1,0,0 (zero latency).
    step("pulse0", 0, 1, 1, 0, 1, 1, 0);
    step("pulse1", 0, 1, 0, 0, 1, 0, 0);
    step("pulse2", 0, 1, 0, 0, 0, 0, 0);
    step("pulse3", 0, 1, 0, 0, 0, 0, 0);

    // Density 1/4 for 400 cycles: y = 1,1,0,0 and credits = 1,0,0,0.
    settle_y();
    n_ones = 0;
    for (int p = 0; p < 100; p++) begin
      step("dens_a", 0, 1, 1, 0, 1, 1, 0);
      step("dens_b", 0, 1, 0, 0, 1, 0, 0);
      step("dens_c", 0, 1, 0, 0, 0, 0, 0);
      step("dens_d", 0, 1, 0, 0, 0, 0, 0);
    end
    settle_y();
    check("dens_ones", 32'(n_ones), 32'd200);

    // Saturation: credits = k after cycle k, clipped at 255; sat rises at 256.
    for (int k = 1; k <= 256; k++)
      step("satfill", 0, 1, 1, 0, 1, (k > MAX_CREDIT) ? MAX_CREDIT : k, (k >= 256));
    // clr_sat during an overflow cycle: overflow wins, so sat stays 1.
    step("clr_ovf", 0, 1, 1, 1, 1, MAX_CREDIT, 1);
    // Drain: 255 further ones. clr_sat on the first non-overflow cycle clears sat.
    settle_y();
    n_ones = 0;
    step("clr_ok", 0, 1, 0, 1, 1, 254, 0);
    for (int j = 2; j <= 255; j++) step("drain", 0, 1, 0, 0, 1, 255 - j, 0);
    step("drain_end", 0, 1, 0, 0, 0, 0, 0);
    settle_y();
    check("drain_ones", 32'(n_ones), 32'd255);

    // Hold: build up 5 credits, freeze for 10 cycles with random a.
    for (int k = 1; k <= 5; k++) step("build5", 0, 1, 1, 0, 1, k, 0);
    for (int k = 0; k < 10; k++)
      step("hold", 0, 0, 1'($urandom_range(0, 1)), 0, 0, 5, 0);
    settle_y();
    n_ones = 0;
    for (int k = 1; k <= 5; k++) step("release", 0, 1, 0, 0, 1, 5 - k, 0);
    step("release_end", 0, 1, 0, 0, 0, 0, 0);
    settle_y();
    check("release_ones", 32'(n_ones), 32'd5);

    // Mid-stream reset with 200 pending credits discards them.
    for (int k = 1; k <= 200; k++) step("build200", 0, 1, 1, 0, 1, k, 0);
    step("mid_rst", 1, 1, 1, 0, 0, 0, 0);
    step("post_rst0", 0, 1, 0, 0, 0, 0, 0);
    step("post_rst1", 0, 1, 0, 0, 0, 0, 0);

    // Bounded wait for the monitor to drain the queue.
    for (int t = 0; t < 20 && q_exp.size() != 0; t++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    #2;
    check("queue_drained", 32'(q_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
